countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 160 ++++++++++++++++
 tb/tb_countdown_timer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with a programmable prescaler, one-shot or
//   periodic operation, pause/resume and abort.
//
//   Parameters
//     WIDTH       counter width in bits
//     PRE_W       prescaler width in bits
//
//   Ports
//     clk         system clock, all state changes on its rising edge
//     rst_n       asynchronous active-low reset
//     load_valid  request to load load_value
//     load_value  countdown start value
//     load_ready  high when a load would be accepted this cycle
//     start       begin or resume counting
//     pause       freeze counting
//     abort       cancel and return to IDLE
//     auto_reload 1 = periodic, 0 = one-shot
//     prescale    one tick every prescale+1 cycles while running
//     count       current count value
//     busy        high while running or paused
//     tc          one-cycle terminal-count pulse
//     done        high once a one-shot countdown has finished
//
//   Input priority per cycle: abort > load > start > pause.
//   All outputs are registers; the status flags are decoded from the
//   next state so they line up with the state register.
module countdown_timer #(
   parameter int WIDTH = 4,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_value,
   output logic             load_ready,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             auto_reload,
   input  logic [PRE_W-1:0] prescale,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARMED  = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_PAUSED = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0]       state, state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] reload, reload_n;
   logic [PRE_W-1:0] presc, presc_n;
   logic             tc_n;
   logic             tick;

   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload;
      presc_n  = presc;
      tc_n     = 1'b0;
      // prescale is compared live, so a reduced value takes effect at once
      tick     = (presc >= prescale);

      if (abort) begin
         state_n  = ST_IDLE;
         count_n  = '0;
         reload_n = '0;
         presc_n  = '0;
      end else if (load_valid && load_ready) begin
         // load_ready is only high in IDLE, ARMED and DONE
         count_n  = load_value;
         reload_n = load_value;
         presc_n  = '0;
         state_n  = ST_ARMED;
      end else begin
         case (state)
            ST_ARMED: begin
               if (start) begin
                  presc_n = '0;
                  state_n = ST_RUN;
               end
            end
            ST_DONE: begin
               if (start) begin
                  count_n = reload;
                  presc_n = '0;
                  state_n = ST_RUN;
               end
            end
            ST_PAUSED: begin
               // resume keeps the partially elapsed prescaler period
               if (start) begin
                  state_n = ST_RUN;
               end
            end
            ST_RUN: begin
               // start outranks pause; a tick landing on the pause cycle
               // is still processed before freezing
               if (pause && !start) begin
                  state_n = ST_PAUSED;
               end
               if (tick) begin
                  presc_n = '0;
                  if (count != '0) begin
                     count_n = count - 1'b1;
                  end else begin
                     tc_n = 1'b1;
                     if (auto_reload) begin
                        count_n = reload;
                     end else begin
                        count_n = '0;
                        state_n = ST_DONE;
                     end
                  end
               end else begin
                  presc_n = presc + 1'b1;
               end
            end
            ST_IDLE: begin
               // start without a prior load is ignored
            end
            default: begin
               state_n = ST_IDLE;
               count_n = '0;
               presc_n = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         count      <= '0;
         reload     <= '0;
         presc      <= '0;
         tc         <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload     <= reload_n;
         presc      <= presc_n;
         tc         <= tc_n;
         done       <= (state_n == ST_DONE);
         busy       <= (state_n == ST_RUN) || (state_n == ST_PAUSED);
         load_ready <= (state_n == ST_IDLE) || (state_n == ST_ARMED) ||
                       (state_n == ST_DONE);
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed bench for countdown_timer (WIDTH=4, PRE_W=4). Inputs change
//   and outputs are sampled 1 time unit after the rising clock edge.
module tb_countdown_timer;

   logic       clk;
   logic       rst_n;
   logic       load_valid;
   logic [3:0] load_value;
   logic       load_ready;
   logic       start;
   logic       pause;
   logic       abort;
   logic       auto_reload;
   logic [3:0] prescale;
   logic [3:0] count;
   logic       busy;
   logic       tc;
   logic       done;

   int unsigned n_tests;
   int unsigned n_fail;

   countdown_timer #(
      .WIDTH (4),
      .PRE_W (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_value  (load_value),
      .load_ready  (load_ready),
      .start       (start),
      .pause       (pause),
      .abort       (abort),
      .auto_reload (auto_reload),
      .prescale    (prescale),
      .count       (count),
      .busy        (busy),
      .tc          (tc),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] v);
      load_valid = 1'b1;
      load_value = v;
      step();
      load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   logic [3:0] per_seq [6];
   int unsigned e;
   logic [3:0] prev;
   logic wrapped;

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      load_valid  = 1'b0;
      load_value  = '0;
      start       = 1'b0;
      pause       = 1'b0;
      abort       = 1'b0;
      auto_reload = 1'b0;
      prescale    = '0;
      per_seq     = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};

      // reset values
      #12;
      check("rst_count", count, 0);
      check("rst_tc", tc, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", load_ready, 1);
      rst_n = 1'b1;
      step();

      // one-shot: load 3, prescale 0
      do_load(4'd3);
      check("os_load_count", count, 3);
      check("os_load_ready", load_ready, 1);
      check("os_load_busy", busy, 0);
      do_start();                          // E0
      check("os_e0_count", count, 3);
      check("os_e0_busy", busy, 1);
      check("os_e0_ready", load_ready, 0);
      for (int i = 2; i >= 0; i--) begin   // E1..E3
         step();
         check("os_count", count, i);
         check("os_tc_early", tc, 0);
      end
      step();                              // E4
      check("os_e4_tc", tc, 1);
      check("os_e4_done", done, 1);
      check("os_e4_count", count, 0);
      check("os_e4_busy", busy, 0);
      step();
      check("os_e5_tc", tc, 0);
      check("os_e5_done", done, 1);
      // start in DONE restarts from the reload value
      do_start();
      check("os_restart_count", count, 3);
      check("os_restart_done", done, 0);
      check("os_restart_busy", busy, 1);
      do_abort();
      check("os_abort_busy", busy, 0);
      check("os_abort_count", count, 0);

      // periodic: load 2, prescale 1 -> period 6
      prescale    = 4'd1;
      auto_reload = 1'b1;
      do_load(4'd2);
      do_start();                          // E0
      for (int k = 1; k <= 12; k++) begin
         step();
         check("per_count", count, per_seq[k % 6]);
         check("per_tc", tc, (k % 6 == 0) ? 1 : 0);
         check("per_busy", busy, 1);
      end
      do_abort();

      // pause/resume: load 5, prescale 0; pause lands on the 4->3 tick
      prescale    = 4'd0;
      auto_reload = 1'b0;
      do_load(4'd5);
      do_start();                          // E0: 5
      step();                              // E1: 4
      check("pz_e1_count", count, 4);
      pause = 1'b1;
      step();                              // E2: 3, paused
      pause = 1'b0;
      check("pz_e2_count", count, 3);
      check("pz_e2_busy", busy, 1);
      for (int i = 0; i < 3; i++) begin    // E3..E5
         step();
         check("pz_hold_count", count, 3);
      end
      start = 1'b1;
      step();                              // E6: resume, no tick
      start = 1'b0;
      check("pz_e6_count", count, 3);
      e = 6;
      while (!tc && e < 30) begin
         step();
         e++;
      end
      check("pz_tc_edge", e, 10);          // 6 without pause, +4
      check("pz_done", done, 1);

      // priority: load ignored in RUN, then abort+load+start together
      do_load(4'd5);
      check("pr_load_done", done, 0);
      check("pr_load_ready", load_ready, 1);
      do_start();                          // E0: 5
      load_valid = 1'b1;
      load_value = 4'd9;
      step();                              // E1
      load_valid = 1'b0;
      check("pr_ignored_count", count, 4);
      check("pr_ignored_busy", busy, 1);
      abort      = 1'b1;
      load_valid = 1'b1;
      load_value = 4'd7;
      start      = 1'b1;
      step();
      abort      = 1'b0;
      load_valid = 1'b0;
      start      = 1'b0;
      check("pr_abort_busy", busy, 0);
      check("pr_abort_count", count, 0);
      check("pr_abort_tc", tc, 0);
      check("pr_abort_ready", load_ready, 1);
      check("pr_abort_done", done, 0);
      step();
      check("pr_after_tc", tc, 0);
      check("pr_after_busy", busy, 0);

      // zero load: terminal on the first tick
      do_load(4'd0);
      do_start();
      check("z_e0_count", count, 0);
      check("z_e0_tc", tc, 0);
      check("z_e0_busy", busy, 1);
      step();
      check("z_e1_tc", tc, 1);
      check("z_e1_done", done, 1);

      // boundary: load 15, prescale 15 -> tc after 256 cycles
      prescale = 4'd15;
      do_load(4'd15);
      do_start();
      e       = 0;
      prev    = count;
      wrapped = 1'b0;
      while (!tc && e < 400) begin
         step();
         e++;
         if (count > prev) wrapped = 1'b1;
         prev = count;
      end
      check("b_tc_cycles", e, 256);
      check("b_count", count, 0);
      check("b_no_wrap", wrapped, 0);
      check("b_done", done, 1);

      // asynchronous reset mid-RUN
      prescale    = 4'd0;
      auto_reload = 1'b1;
      do_load(4'd9);
      do_start();
      step();
      step();
      check("ar_pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_count", count, 0);
      check("ar_busy", busy, 0);
      check("ar_ready", load_ready, 1);
      check("ar_tc", tc, 0);
      check("ar_done", done, 0);
      #3;
      rst_n = 1'b1;
      step();
      do_start();
      check("ar_start_busy", busy, 0);
      check("ar_start_count", count, 0);
      check("ar_start_ready", load_ready, 1);
      step();
      check("ar_idle_busy", busy, 0);
      check("ar_idle_tc", tc, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
